// File: rtl/xorshift_pkg.sv
// xorshift_pkg
//   Shared definitions for the xorshift PRNG bank:
//   - shift triplets for the 16-bit and 32-bit xorshift variants
//   - golden-ratio lane-spread constants and zero-seed substitutes
//   - the bank state enum
//   - xs_step(): one xorshift step for the selected width
//   - lane_seed(): derives a lane seed from a base seed
//   Values narrower than 32 bits are carried zero-extended in 32-bit containers
//   so a single function serves both widths.
package xorshift_pkg;

    // 16-bit variant: t=s^(s>>7); t=t^(t<<9); s'=t^(t>>8)
    localparam int XS16_A = 7;
    localparam int XS16_B = 9;
    localparam int XS16_C = 8;

    // 32-bit variant: t=s^(s<<13); t=t^(t>>17); s'=t^(t<<5)
    localparam int XS32_A = 13;
    localparam int XS32_B = 17;
    localparam int XS32_C = 5;

    localparam logic [15:0] GOLDEN16   = 16'h9E37;
    localparam logic [31:0] GOLDEN32   = 32'h9E3779B9;
    localparam logic [15:0] ZERO_SUB16 = 16'hACE1;
    localparam logic [31:0] ZERO_SUB32 = 32'hACE1ACE1;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    // One xorshift step. For width 16 only s[15:0] is used and the result is
    // returned zero-extended.
    function automatic logic [31:0] xs_step(input int width, input logic [31:0] s);
        logic [15:0] t16;
        logic [31:0] t32;
        t16 = '0;
        t32 = '0;
        if (width == 16) begin
            t16 = s[15:0] ^ (s[15:0] >> XS16_A);
            t16 = t16 ^ (t16 << XS16_B);
            t16 = t16 ^ (t16 >> XS16_C);
            xs_step = {16'h0000, t16};
        end else begin
            t32 = s ^ (s << XS32_A);
            t32 = t32 ^ (t32 >> XS32_B);
            t32 = t32 ^ (t32 << XS32_C);
            xs_step = t32;
        end
    endfunction

    // Lane seed: base ^ trunc(idx*GOLDEN), with the all-zero lock-up state
    // replaced by a fixed nonzero substitute.
    function automatic logic [31:0] lane_seed(input int width, input logic [31:0] base,
                                              input int idx);
        logic [31:0] mix;
        logic [31:0] seed;
        if (width == 16) begin
            mix  = 32'(idx) * {16'h0000, GOLDEN16};
            seed = (base ^ mix) & 32'h0000_FFFF;
            if (seed == 32'h0) seed = {16'h0000, ZERO_SUB16};
        end else begin
            mix  = 32'(idx) * GOLDEN32;
            seed = base ^ mix;
            if (seed == 32'h0) seed = ZERO_SUB32;
        end
        lane_seed = seed;
    endfunction

endpackage

// File: rtl/xorshift_lane.sv
// xorshift_lane
//   Single xorshift lane: a WIDTH-bit state register that either loads a new
//   seed or advances by one xorshift step. Load has priority over step.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset (to RESET_VAL)
//     step         advance the lane by one step this cycle
//     load         load load_val this cycle (overrides step)
//     load_val     seed to load
//     value        registered lane state
module xorshift_lane
    import xorshift_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(16'hACE1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [31:0]      q_ext;
    logic [31:0]      stepped;

    always_comb begin
        q_ext   = 32'(q);
        stepped = xs_step(WIDTH, q_ext);
        q_next  = stepped[WIDTH-1:0];
    end

    // Upper bits of the 32-bit container are zero for narrow lanes.
    if (WIDTH < 32) begin : g_pad
        logic unused_hi;
        assign unused_hi = ^stepped[31:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= q_next;
        end
    end

    assign value = q;

endmodule

// File: rtl/xorshift_prng_bank.sv
// xorshift_prng_bank
//   NUM_CH independent xorshift lanes presented together on a valid/ready
//   stream, with runtime reseed and a programmable warm-up after every seed
//   load.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     reseed_valid   reseed request (must be held until reseed_ready)
//     reseed_seed    new base seed
//     reseed_ready   high in RUN; a reseed fires on reseed_valid && reseed_ready
//     out_valid      out_data holds a fresh draw (high in RUN)
//     out_ready      consumer accepts the draw
//     out_data       lane i in bits [i*WIDTH +: WIDTH], always registered state
//     busy           high during warm-up
//   Handshake: a transfer happens on a rising edge where valid && ready are both
//   high; out_data is held stable while out_valid && !out_ready. When a reseed
//   and an output transfer fire together the consumer takes the current
//   (pre-reseed) draw and the seed load replaces the step.
module xorshift_prng_bank
    import xorshift_pkg::*;
#(
    parameter int               WIDTH  = 16,
    parameter int               NUM_CH = 4,
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(16'h1ACE),
    parameter int               WARMUP = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reseed_valid,
    input  logic [WIDTH-1:0]          reseed_seed,
    output logic                      reseed_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CH*WIDTH-1:0]   out_data,
    output logic                      busy
);

    if (!(WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
        $error("xorshift_prng_bank: WIDTH must be 16 or 32");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("xorshift_prng_bank: NUM_CH must be 1..16");
    end
    if (WARMUP < 0 || WARMUP > 255) begin : g_bad_warmup
        $error("xorshift_prng_bank: WARMUP must be 0..255");
    end

    localparam logic [7:0] WARMUP_CNT  = 8'(WARMUP);
    // With no warm-up the bank goes straight to RUN after any seed load.
    localparam state_t     RESET_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

    state_t     state;
    logic [7:0] cnt;
    logic       reseed_fire;
    logic       out_fire;
    logic       lane_step;

    // out_valid, reseed_ready and busy are decodes of the one-bit state
    // register, so they are glitch-free registered values.
    assign out_valid    = (state == ST_RUN);
    assign reseed_ready = (state == ST_RUN);
    assign busy         = (state == ST_WARMUP);

    assign reseed_fire  = reseed_valid && reseed_ready;
    assign out_fire     = out_valid && out_ready;
    assign lane_step    = busy || out_fire;

    // FSM and warm-up counter. cnt is only meaningful in WARMUP; it leaves for
    // RUN on the edge that consumes cnt==1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
            cnt   <= WARMUP_CNT;
        end else if (reseed_fire) begin
            state <= RESET_STATE;
            cnt   <= WARMUP_CNT;
        end else if (state == ST_WARMUP) begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) begin
                state <= ST_RUN;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        localparam logic [31:0]      RST_FULL = lane_seed(WIDTH, 32'(SEED), i);
        localparam logic [WIDTH-1:0] RST_VAL  = RST_FULL[WIDTH-1:0];

        logic [31:0]      rs_full;
        logic [WIDTH-1:0] rs_val;
        logic [WIDTH-1:0] lane_value;

        always_comb begin
            rs_full = lane_seed(WIDTH, 32'(reseed_seed), i);
            rs_val  = rs_full[WIDTH-1:0];
        end

        if (WIDTH < 32) begin : g_pad
            logic unused_hi;
            assign unused_hi = ^rs_full[31:WIDTH];
        end

        xorshift_lane #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RST_VAL)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .step     (lane_step),
            .load     (reseed_fire),
            .load_val (rs_val),
            .value    (lane_value)
        );

        assign out_data[i*WIDTH +: WIDTH] = lane_value;
    end

endmodule

// File: tb/tb_xorshift_prng_bank.sv
// tb_xorshift_prng_bank
//   Three bank instances sharing clock and reset:
//     a: WIDTH=16 NUM_CH=2 WARMUP=0
//     b: WIDTH=16 NUM_CH=2 WARMUP=8
//     c: WIDTH=32 NUM_CH=4 WARMUP=3
//   Directed vectors with hand-computed values plus a small reference model
//   for longer sequences. Inputs are driven and outputs sampled on the
//   falling clock edge.
module tb_xorshift_prng_bank;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        a_rv, a_rr, a_ov, a_or, a_busy;
    logic [15:0] a_rs;
    logic [31:0] a_od;
    logic        b_rv, b_rr, b_ov, b_or, b_busy;
    logic [15:0] b_rs;
    logic [31:0] b_od;
    logic        c_rv, c_rr, c_ov, c_or, c_busy;
    logic [31:0] c_rs;
    logic [127:0] c_od;

    xorshift_prng_bank #(.WIDTH(16), .NUM_CH(2), .SEED(16'h1ACE), .WARMUP(0)) u_a (
        .clk(clk), .rst_n(rst_n), .reseed_valid(a_rv), .reseed_seed(a_rs),
        .reseed_ready(a_rr), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .busy(a_busy));

    xorshift_prng_bank #(.WIDTH(16), .NUM_CH(2), .SEED(16'h1ACE), .WARMUP(8)) u_b (
        .clk(clk), .rst_n(rst_n), .reseed_valid(b_rv), .reseed_seed(b_rs),
        .reseed_ready(b_rr), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .busy(b_busy));

    xorshift_prng_bank #(.WIDTH(32), .NUM_CH(4), .SEED(32'hC0FFEE11), .WARMUP(3)) u_c (
        .clk(clk), .rst_n(rst_n), .reseed_valid(c_rv), .reseed_seed(c_rs),
        .reseed_ready(c_rr), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
        .busy(c_busy));

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] m_step16(input logic [15:0] s);
        logic [15:0] t;
        t = s ^ (s >> 7);
        t = t ^ (t << 9);
        return t ^ (t >> 8);
    endfunction

    function automatic logic [31:0] m_step32(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 17);
        return t ^ (t << 5);
    endfunction

    function automatic logic [15:0] m_seed16(input logic [15:0] b, input int i);
        logic [15:0] v;
        v = b ^ 16'(i * 32'h9E37);
        return (v == 16'h0) ? 16'hACE1 : v;
    endfunction

    function automatic logic [31:0] m_seed32(input logic [31:0] b, input int i);
        logic [31:0] v;
        v = b ^ 32'(i * 32'h9E3779B9);
        return (v == 32'h0) ? 32'hACE1ACE1 : v;
    endfunction

    function automatic logic [15:0] m_adv16(input logic [15:0] s, input int n);
        logic [15:0] v;
        v = s;
        for (int k = 0; k < n; k++) v = m_step16(v);
        return v;
    endfunction

    function automatic logic [127:0] m_pack32(input logic [31:0] l0, input logic [31:0] l1,
                                              input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // ---------------- driver / stimulus ----------------
    logic [15:0] s0, s1;
    logic [31:0] cs[4];
    int mm, zeros;

    initial begin
        rst_n = 1'b0;
        a_rv = 0; a_or = 0; a_rs = '0;
        b_rv = 0; b_or = 0; b_rs = '0;
        c_rv = 0; c_or = 0; c_rs = '0;
        #12;

        // Reset values
        check("a_rst_ctrl", 128'({a_ov, a_rr, a_busy}), 128'(3'b110));
        check("a_rst_data", 128'(a_od), 128'({16'h84F9, 16'h1ACE}));
        check("b_rst_ctrl", 128'({b_ov, b_rr, b_busy}), 128'(3'b001));
        check("b_rst_data", 128'(b_od), 128'({16'h84F9, 16'h1ACE}));
        for (int i = 0; i < 4; i++) cs[i] = m_seed32(32'hC0FFEE11, i);
        check("c_rst_ctrl", 128'({c_ov, c_busy}), 128'(2'b01));
        check("c_rst_data", c_od, m_pack32(cs[0], cs[1], cs[2], cs[3]));

        // b: warm-up of exactly 8 cycles, out_ready held high
        b_or = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("b_warmup", 128'({b_ov, b_busy}), 128'(2'b01));
            @(negedge clk);
        end
        s0 = m_adv16(16'h1ACE, 8);
        s1 = m_adv16(16'h84F9, 8);
        for (int d = 0; d < 20; d++) begin
            exp_q.push_back({s1, s0});
            s0 = m_step16(s0);
            s1 = m_step16(s1);
        end
        for (int d = 0; d < 20; d++) begin
            if (d == 10) begin
                b_or = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    check("b_stall_data", 128'(b_od), 128'(exp_q[0]));
                    check("b_stall_valid", 128'(b_ov), 128'(1'b1));
                    @(negedge clk);
                end
                b_or = 1'b1;
            end
            check("b_stream", 128'({b_ov, b_od}), 128'({1'b1, exp_q.pop_front()}));
            @(negedge clk);
        end
        b_or = 1'b0;

        // a: WARMUP=0 vectors
        check("a_hold_seed", 128'(a_od), 128'({16'h84F9, 16'h1ACE}));
        a_or = 1'b1;
        @(negedge clk);
        a_or = 1'b0;
        check("a_step_lane0", 128'(a_od[15:0]), 128'(16'hEC17));
        check("a_step_lane1", 128'(a_od[31:16]), 128'(m_step16(16'h84F9)));

        // Reseed with zero base: lane0 substitutes ACE1
        a_rv = 1'b1; a_rs = 16'h0000;
        @(negedge clk);
        a_rv = 1'b0;
        check("a_zero_reseed", 128'({a_ov, a_od}), 128'({1'b1, 16'h9E37, 16'hACE1}));

        // Reseed concurrent with output fire
        a_rv = 1'b1; a_rs = 16'h1234; a_or = 1'b1;
        check("a_old_draw", 128'({a_rr, a_ov, a_od}), 128'({2'b11, 16'h9E37, 16'hACE1}));
        @(negedge clk);
        a_rv = 1'b0; a_or = 1'b0;
        check("a_new_seed", 128'({a_ov, a_od}), 128'({1'b1, 16'h8C03, 16'h1234}));

        // Long run: model tracking and zero lock-up scan
        s0 = 16'h1234; s1 = 16'h8C03; mm = 0; zeros = 0;
        a_or = 1'b1;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            s0 = m_step16(s0);
            s1 = m_step16(s1);
            if (a_od !== {s1, s0}) mm++;
            if (a_od[15:0] == 16'h0 || a_od[31:16] == 16'h0) zeros++;
        end
        a_or = 1'b0;
        check("a_long_model", 128'(mm), 128'(0));
        check("a_no_zero", 128'(zeros), 128'(0));

        // b: reseed concurrent with fire, held request ignored during warm-up
        b_rv = 1'b1; b_rs = 16'hBEEF; b_or = 1'b1;
        check("b_rs_ready", 128'(b_rr), 128'(1'b1));
        @(negedge clk);
        b_or = 1'b0; b_rs = 16'h5555;
        for (int j = 0; j < 8; j++) begin
            check("b_rs_warm", 128'({b_ov, b_busy, b_rr}), 128'(3'b010));
            if (j == 3) b_rv = 1'b0;
            @(negedge clk);
        end
        check("b_rs_data", 128'({b_ov, b_od}),
              128'({1'b1, m_adv16(16'h20D8, 8), m_adv16(16'hBEEF, 8)}));

        // Asynchronous reset mid-warm-up (b) and mid-stream (a)
        b_rv = 1'b1; b_rs = 16'h7777;
        @(negedge clk);
        b_rv = 1'b0;
        a_or = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("b_arst_ctrl", 128'({b_ov, b_busy, b_rr}), 128'(3'b010));
        check("b_arst_data", 128'(b_od), 128'({16'h84F9, 16'h1ACE}));
        check("a_arst_data", 128'({a_ov, a_od}), 128'({1'b1, 16'h84F9, 16'h1ACE}));
        check("c_arst_data", 128'(c_ov), 128'(1'b0));
        a_or = 1'b0;
        b_or = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("b_cold_warm", 128'(b_ov), 128'(1'b0));
            @(negedge clk);
        end
        check("b_cold_data", 128'({b_ov, b_od}),
              128'({1'b1, m_adv16(16'h84F9, 8), m_adv16(16'h1ACE, 8)}));
        b_or = 1'b0;

        // c: 32-bit, 4 lanes; warmed 3 steps and idle since reset release
        for (int i = 0; i < 4; i++) cs[i] = m_step32(m_step32(m_step32(cs[i])));
        check("c_warm_data", {96'(0), 31'(0), c_ov}, 128'(1'b1));
        check("c_first", c_od, m_pack32(cs[0], cs[1], cs[2], cs[3]));
        mm = 0;
        c_or = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) cs[i] = m_step32(cs[i]);
            if (c_od !== m_pack32(cs[0], cs[1], cs[2], cs[3])) mm++;
        end
        c_or = 1'b0;
        check("c_long_model", 128'(mm), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
